// File: rtl/imem_responder_if.sv
// Fetch/loader bundle for imem_responder. With IMEM_PARITY_EN defined the
// bundle also carries the registered parity-error flag im_perr_o.
interface imem_responder_if #(
    parameter int LEN_W = 16
);
    logic [31:0]      im_addr_i;
    logic [31:0]      im_dout_o;
    logic             im_misalign_o;
`ifdef IMEM_PARITY_EN
    logic             im_perr_o;
`endif
    logic             ld_start_i;
    logic [31:0]      ld_base_i;
    logic [LEN_W-1:0] ld_len_i;
    logic [7:0]       ld_byte_i;
    logic             ld_valid_i;
    logic             ld_ready_o;
    logic             ld_busy_o;
    logic             ld_done_o;
    logic             ld_err_o;

    modport master (
        output im_addr_i, ld_start_i, ld_base_i, ld_len_i, ld_byte_i, ld_valid_i,
`ifdef IMEM_PARITY_EN
        input  im_perr_o,
`endif
        input  im_dout_o, im_misalign_o, ld_ready_o, ld_busy_o, ld_done_o, ld_err_o
    );

    modport slave (
        input  im_addr_i, ld_start_i, ld_base_i, ld_len_i, ld_byte_i, ld_valid_i,
`ifdef IMEM_PARITY_EN
        output im_perr_o,
`endif
        output im_dout_o, im_misalign_o, ld_ready_o, ld_busy_o, ld_done_o, ld_err_o
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: 1-cycle registered fetch port plus a byte-serial
// program loader. Optional per-word even parity with macro IMEM_PARITY_EN.
module imem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LEN_W       = 16
) (
    input logic             clk_i,
    input logic             rst_i,
    imem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int SW = ((AW > LEN_W) ? AW : LEN_W) + 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [31:0]      mem_q [DEPTH_WORDS];
`ifdef IMEM_PARITY_EN
    logic             mem_par_q [DEPTH_WORDS];
    logic             perr_q;
`endif

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [LEN_W-1:0] left_q, left_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             zdone_q, zdone_d;
    logic [31:0]      dout_q;
    logic             misalign_q;

    logic             accept;
    logic             we;
    logic [31:0]      wdata;
    logic             base_ok;
    logic [SW-1:0]    end_idx;
    logic             rd_in_range;
    logic [AW-1:0]    rd_idx;

    assign accept      = (state_q == S_LOAD) && bus.ld_valid_i;
    assign rd_in_range = ~|bus.im_addr_i[31:AW+2];
    assign rd_idx      = bus.im_addr_i[AW+1:2];

    // Range check is done wide enough that base + length can never wrap.
    assign end_idx = SW'(bus.ld_base_i[AW+1:2]) + SW'(bus.ld_len_i);
    assign base_ok = (bus.ld_base_i[1:0] == 2'b00) && (~|bus.ld_base_i[31:AW+2]) &&
                     (end_idx <= SW'(DEPTH_WORDS));

    // The first three bytes of a word are held per lane; the fourth goes straight to memory.
    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_lane
        logic [7:0] byte_q;
        always_ff @(posedge clk_i) begin
            if (accept && (cnt_q == 2'(gi))) begin
                byte_q <= bus.ld_byte_i;
            end
        end
    end
    assign wdata = {bus.ld_byte_i, g_lane[2].byte_q, g_lane[1].byte_q, g_lane[0].byte_q};

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        left_d  = left_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        zdone_d = 1'b0;
        we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.ld_start_i) begin
                    if (!base_ok) begin
                        err_d = 1'b1;
                    end else if (bus.ld_len_i == '0) begin
                        zdone_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                        wptr_d  = bus.ld_base_i[AW+1:2];
                        left_d  = bus.ld_len_i;
                        cnt_d   = 2'd0;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        we     = 1'b1;
                        wptr_d = wptr_q + AW'(1);
                        left_d = left_q - LEN_W'(1);
                        if (left_q == LEN_W'(1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            left_q  <= '0;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            left_q  <= left_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            zdone_q <= zdone_d;
        end
    end

    // Memory is never reset; a reset landing on a completing byte drops that word.
    always_ff @(posedge clk_i) begin
        if (we && !rst_i) begin
            mem_q[wptr_q] <= wdata;
`ifdef IMEM_PARITY_EN
            mem_par_q[wptr_q] <= ^wdata;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_q     <= 32'h0;
            misalign_q <= 1'b0;
`ifdef IMEM_PARITY_EN
            perr_q     <= 1'b0;
`endif
        end else begin
            misalign_q <= |bus.im_addr_i[1:0];
            if (state_q != S_IDLE) begin
                dout_q <= NOP;
            end else if (rd_in_range) begin
                dout_q <= mem_q[rd_idx];
            end else begin
                dout_q <= 32'h0;
            end
`ifdef IMEM_PARITY_EN
            perr_q <= (state_q == S_IDLE) && rd_in_range &&
                      (mem_par_q[rd_idx] != ^mem_q[rd_idx]);
`endif
        end
    end

    assign bus.im_dout_o     = dout_q;
    assign bus.im_misalign_o = misalign_q;
`ifdef IMEM_PARITY_EN
    assign bus.im_perr_o     = perr_q;
`endif
    assign bus.ld_ready_o    = (state_q == S_LOAD);
    assign bus.ld_busy_o     = (state_q != S_IDLE);
    assign bus.ld_done_o     = (state_q == S_DONE) || zdone_q;
    assign bus.ld_err_o      = err_q;
endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed loads, read vector table,
// reject/boundary cases, reset mid-load, and randomized loads against a word-array model.
module tb_imem_responder;
    localparam int DEPTH = 1024;
    localparam int LEN_W = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_dout;
        logic        exp_mis;
    } rd_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_responder_if #(.LEN_W(LEN_W)) bus ();
    imem_responder #(.DEPTH_WORDS(DEPTH), .LEN_W(LEN_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] model_mem [DEPTH];
    bit          known     [DEPTH];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read one address and compare against the model (unknown words only check the flag).
    task automatic do_read(input logic [31:0] addr, input bit exp_perr);
        logic [31:0] exp;
        bit          have;
        int          idx;
        bus.im_addr_i = addr;
        step();
        idx  = int'(addr >> 2);
        have = 1'b1;
        if (addr >= 32'(DEPTH * 4)) exp = 32'h0;
        else if (known[idx])        exp = model_mem[idx];
        else begin
            exp  = 32'h0;
            have = 1'b0;
        end
        $display("read addr=%h dout=%h mis=%b", addr, bus.im_dout_o, bus.im_misalign_o);
        if (have) chk("read_dout", bus.im_dout_o, exp);
        chk("read_misalign", 32'(bus.im_misalign_o), 32'(|addr[1:0]));
`ifdef IMEM_PARITY_EN
        chk("read_perr", 32'(bus.im_perr_o), 32'(exp_perr));
`else
        if (exp_perr) $display("note: parity not built");
`endif
    endtask

    // Issue a load; stall_at inserts 3 idle cycles before that byte; stop_after ends early.
    task automatic do_load(input logic [31:0] base, input int nwords, input logic [7:0] bytes[$],
                           input int gap_pct, input int stall_at, input int stop_after);
        int idx    = 0;
        int cyc    = 0;
        int stalls = 0;
        int nb     = nwords * 4;
        bus.ld_start_i = 1'b1;
        bus.ld_base_i  = base;
        bus.ld_len_i   = LEN_W'(nwords);
        step();
        bus.ld_start_i = 1'b0;
        chk("load_busy_start", 32'(bus.ld_busy_o), 32'd1);
        chk("load_ready_start", 32'(bus.ld_ready_o), 32'd1);
        while (idx < nb && idx != stop_after && cyc < 2000) begin
            cyc++;
            if ((idx == stall_at && stalls < 3) || ($urandom_range(99) < gap_pct)) begin
                if (idx == stall_at) stalls++;
                bus.ld_valid_i = 1'b0;
                step();
                chk("stall_ready", 32'(bus.ld_ready_o), 32'd1);
                chk("stall_done", 32'(bus.ld_done_o), 32'd0);
            end else begin
                bus.ld_valid_i = 1'b1;
                bus.ld_byte_i  = bytes[idx];
                step();
                idx++;
                chk("byte_done", 32'(bus.ld_done_o), 32'(idx == nb));
                chk("byte_ready", 32'(bus.ld_ready_o), 32'(idx != nb));
            end
            chk("busy_dout_nop", bus.im_dout_o, NOP);
        end
        if (cyc >= 2000) chk("load_cycle_budget", 32'(cyc), 32'd0);
        bus.ld_valid_i = 1'b0;
        for (int w = 0; w < nwords; w++) begin
            if (4 * (w + 1) <= idx) begin
                model_mem[int'(base >> 2) + w] = {bytes[4*w+3], bytes[4*w+2], bytes[4*w+1], bytes[4*w]};
                known[int'(base >> 2) + w]     = 1'b1;
            end
        end
        $display("load base=%h len=%0d bytes_accepted=%0d", base, nwords, idx);
        if (idx == nb) begin
            step();
            chk("load_busy_end", 32'(bus.ld_busy_o), 32'd0);
            chk("load_done_end", 32'(bus.ld_done_o), 32'd0);
        end
    endtask

    task automatic do_reject(input logic [31:0] base, input int len, input bit exp_err, input bit exp_done);
        bus.ld_start_i = 1'b1;
        bus.ld_base_i  = base;
        bus.ld_len_i   = LEN_W'(len);
        step();
        bus.ld_start_i = 1'b0;
        $display("request base=%h len=%0d err=%b done=%b", base, len, bus.ld_err_o, bus.ld_done_o);
        chk("req_err", 32'(bus.ld_err_o), 32'(exp_err));
        chk("req_done", 32'(bus.ld_done_o), 32'(exp_done));
        chk("req_busy", 32'(bus.ld_busy_o), 32'd0);
        step();
        chk("req_err_pulse", 32'(bus.ld_err_o), 32'd0);
        chk("req_done_pulse", 32'(bus.ld_done_o), 32'd0);
        chk("req_busy_after", 32'(bus.ld_busy_o), 32'd0);
    endtask

    initial begin
        rd_vec_t     vecs [6];
        logic [7:0]  bq [$];
        logic [31:0] a;
        int          n;
        int          b;

        bus.im_addr_i  = 32'h0;
        bus.ld_start_i = 1'b0;
        bus.ld_base_i  = 32'h0;
        bus.ld_len_i   = '0;
        bus.ld_byte_i  = 8'h0;
        bus.ld_valid_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

        step();
        step();
        chk("rst_dout", bus.im_dout_o, 32'h0);
        chk("rst_misalign", 32'(bus.im_misalign_o), 32'd0);
        chk("rst_ready", 32'(bus.ld_ready_o), 32'd0);
        chk("rst_busy", 32'(bus.ld_busy_o), 32'd0);
        chk("rst_done", 32'(bus.ld_done_o), 32'd0);
        chk("rst_err", 32'(bus.ld_err_o), 32'd0);
`ifdef IMEM_PARITY_EN
        chk("rst_perr", 32'(bus.im_perr_o), 32'd0);
`endif
        rst = 1'b0;
        step();

        // Two-word program, continuous valid, fetch held at 0 during the load.
        bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        do_load(32'h0, 2, bq, 0, -1, -1);

        vecs[0] = '{32'h0000_0000, 32'h0000_0013, 1'b0};
        vecs[1] = '{32'h0000_0004, 32'h0010_0093, 1'b0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0013, 1'b0};
        vecs[3] = '{32'h0000_0006, 32'h0010_0093, 1'b1};
        vecs[4] = '{32'h0000_1000, 32'h0000_0000, 1'b0};
        vecs[5] = '{32'h0000_1003, 32'h0000_0000, 1'b1};
        for (int i = 0; i < 6; i++) begin
            bus.im_addr_i = vecs[i].addr;
            step();
            $display("vector %0d addr=%h dout=%h mis=%b", i, vecs[i].addr, bus.im_dout_o, bus.im_misalign_o);
            chk("vec_dout", bus.im_dout_o, vecs[i].exp_dout);
            chk("vec_misalign", 32'(bus.im_misalign_o), 32'(vecs[i].exp_mis));
        end

        // One-word load with valid dropped after two bytes.
        bq = '{8'h37, 8'h05, 8'h00, 8'h80};
        do_load(32'h8, 1, bq, 0, 2, -1);
        do_read(32'h8, 1'b0);

        do_reject(32'h2, 1, 1'b1, 1'b0);
        do_reject(32'hFFC, 2, 1'b1, 1'b0);
        do_reject(32'h0010_0000, 1, 1'b1, 1'b0);
        do_reject(32'h40, 0, 1'b0, 1'b1);

        // Last word of memory is a legal single-word target.
        bq = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_load(32'hFFC, 1, bq, 0, -1, -1);
        do_read(32'hFFC, 1'b0);

        // Reset after 6 of 8 bytes: word 0 committed, word 1 untouched.
        bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
        do_load(32'h0, 2, bq, 0, -1, 6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", 32'(bus.ld_busy_o), 32'd0);
        chk("midrst_ready", 32'(bus.ld_ready_o), 32'd0);
        step();
        chk("midrst_busy2", 32'(bus.ld_busy_o), 32'd0);
        do_read(32'h0, 1'b0);
        do_read(32'h4, 1'b0);

        // Randomized loads with random valid gaps, then random fetches.
        for (int t = 0; t < 6; t++) begin
            n = int'($urandom_range(1, 4));
            b = int'($urandom_range(0, DEPTH - n));
            bq = {};
            for (int k = 0; k < 4 * n; k++) bq.push_back(8'($urandom));
            bus.im_addr_i = $urandom;
            do_load(32'(b * 4), n, bq, 30, -1, -1);
            for (int r = 0; r < 5; r++) begin
                if (r < 3) a = 32'((b + int'($urandom_range(0, n - 1))) * 4) | 32'($urandom_range(0, 3));
                else       a = 32'($urandom_range(0, 4 * DEPTH + 256));
                do_read(a, 1'b0);
            end
        end

`ifdef IMEM_PARITY_EN
        dut.mem_par_q[0] = ~dut.mem_par_q[0];
        do_read(32'h0, 1'b1);
        dut.mem_par_q[0] = ~dut.mem_par_q[0];
        do_read(32'h0, 1'b0);
        do_read(32'h8, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
